// File: rtl/pe_add_acc_if.sv
// Operand, handshake and result bundle for pe_add_acc.
// The master drives operands and result-ready; the slave (the PE) drives results.
interface pe_add_acc_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int ACC_WIDTH   = 16
);
  logic [DATA_COPIES*DATA_WIDTH-1:0] i_wdata;
  logic                              i_wdata_vld;
  logic [DATA_COPIES*DATA_WIDTH-1:0] i_mdata;
  logic                              i_mdata_vld;
  logic                              i_in_vld;
  logic                              o_in_rdy;
  logic                              i_mode;
  logic                              i_acc_last;
  logic                              i_acc_clear;
  logic [DATA_COPIES*ACC_WIDTH-1:0]  o_result;
  logic                              o_result_vld;
  logic                              i_result_rdy;
  logic [DATA_COPIES-1:0]            o_sat;
  logic                              o_busy;

  modport master (
    output i_wdata, i_wdata_vld, i_mdata, i_mdata_vld, i_in_vld,
           i_mode, i_acc_last, i_acc_clear, i_result_rdy,
    input  o_in_rdy, o_result, o_result_vld, o_sat, o_busy
  );

  modport slave (
    input  i_wdata, i_wdata_vld, i_mdata, i_mdata_vld, i_in_vld,
           i_mode, i_acc_last, i_acc_clear, i_result_rdy,
    output o_in_rdy, o_result, o_result_vld, o_sat, o_busy
  );
endinterface

// File: rtl/pe_add_acc.sv
// Multi-lane signed adder / group accumulator with optional saturation and a
// single registered result stage under valid/ready flow control.
module pe_add_acc #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int ACC_WIDTH   = 16,
  parameter int SAT_EN      = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  pe_add_acc_if.slave  bus
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                           state_q;
  logic [ACC_WIDTH-1:0]             acc_q      [DATA_COPIES];
  logic [DATA_COPIES-1:0]           sticky_q;
  logic [DATA_COPIES*ACC_WIDTH-1:0] result_q;
  logic [DATA_COPIES-1:0]           sat_q;
  logic                             result_vld_q;

  logic                             in_rdy;
  logic                             accept;
  logic                             grp_start;
  logic                             acc_mode;
  logic                             load;
  logic [ACC_WIDTH-1:0]             nxt_acc    [DATA_COPIES];
  logic [DATA_COPIES-1:0]           nxt_sticky;
  logic [DATA_COPIES*ACC_WIDTH-1:0] nxt_result;
  logic [DATA_COPIES-1:0]           nxt_sat;

  assign in_rdy = ~result_vld_q | bus.i_result_rdy;

  // A clear coincident with a beat makes that beat open a fresh group,
  // so group start and the effective mode both honour i_acc_clear.
  always_comb begin
    logic [DATA_WIDTH-1:0]  a;
    logic [DATA_WIDTH-1:0]  b;
    logic [DATA_WIDTH:0]    sum;
    logic [ACC_WIDTH-1:0]   base;
    logic [ACC_WIDTH:0]     full;
    logic                   ovf;
    logic [ACC_WIDTH-1:0]   add_res;
    grp_start  = (state_q == IDLE) | bus.i_acc_clear;
    acc_mode   = grp_start ? bus.i_mode : 1'b1;
    accept     = bus.i_in_vld & in_rdy;
    load       = accept & (~acc_mode | bus.i_acc_last);
    nxt_sticky = '0;
    nxt_result = '0;
    nxt_sat    = '0;
    for (int unsigned i = 0; i < DATA_COPIES; i++) begin
      a    = bus.i_wdata_vld ? bus.i_wdata[DATA_WIDTH*i +: DATA_WIDTH] : '0;
      b    = bus.i_mdata_vld ? bus.i_mdata[DATA_WIDTH*i +: DATA_WIDTH] : '0;
      sum  = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      base = grp_start ? '0 : acc_q[i];
      full = {base[ACC_WIDTH-1], base} + (ACC_WIDTH+1)'($signed(sum));
      ovf  = full[ACC_WIDTH] ^ full[ACC_WIDTH-1];
      if ((SAT_EN != 0) && ovf) begin
        nxt_acc[i] = full[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end else begin
        nxt_acc[i] = full[ACC_WIDTH-1:0];
      end
      if (SAT_EN != 0) begin
        nxt_sticky[i] = (grp_start ? 1'b0 : sticky_q[i]) | ovf;
      end
      add_res = ACC_WIDTH'($signed(sum));
      nxt_result[ACC_WIDTH*i +: ACC_WIDTH] = acc_mode ? nxt_acc[i] : add_res;
      nxt_sat[i] = acc_mode & nxt_sticky[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      sticky_q     <= '0;
      result_q     <= '0;
      sat_q        <= '0;
      result_vld_q <= 1'b0;
      for (int unsigned i = 0; i < DATA_COPIES; i++) acc_q[i] <= '0;
    end else begin
      if (accept) begin
        state_q  <= (acc_mode & ~bus.i_acc_last) ? ACC : IDLE;
        sticky_q <= nxt_sticky;
        for (int unsigned i = 0; i < DATA_COPIES; i++) acc_q[i] <= nxt_acc[i];
      end else if (bus.i_acc_clear) begin
        state_q  <= IDLE;
        sticky_q <= '0;
        for (int unsigned i = 0; i < DATA_COPIES; i++) acc_q[i] <= '0;
      end
      if (load) begin
        result_q     <= nxt_result;
        sat_q        <= nxt_sat;
        result_vld_q <= 1'b1;
      end else if (bus.i_result_rdy) begin
        result_vld_q <= 1'b0;
      end
    end
  end

  assign bus.o_in_rdy     = in_rdy;
  assign bus.o_result     = result_q;
  assign bus.o_sat        = sat_q;
  assign bus.o_result_vld = result_vld_q;
  assign bus.o_busy       = (state_q == ACC) | result_vld_q;

endmodule

// File: tb/tb_pe_add_acc.sv
// Directed bench for pe_add_acc: ADD, masking, ACC groups, saturation,
// backpressure, and reset/clear in the middle of a group.
module tb_pe_add_acc;
  localparam int DW = 8;
  localparam int DC = 4;
  localparam int AW = 12;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 i_clk = ~i_clk;

  pe_add_acc_if #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .ACC_WIDTH(AW)) bus ();

  pe_add_acc #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .ACC_WIDTH(AW), .SAT_EN(1)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input int v);
    logic [AW-1:0] l;
    l = v[AW-1:0];
    return 64'({DC{l}});
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ops(input int a, input int b);
    logic [DW-1:0] la;
    logic [DW-1:0] lb;
    la = a[DW-1:0];
    lb = b[DW-1:0];
    bus.i_wdata = {DC{la}};
    bus.i_mdata = {DC{lb}};
  endtask

  task automatic beat(input int a, input int b, input logic mode, input logic last,
                      input logic clr);
    set_ops(a, b);
    bus.i_mode      = mode;
    bus.i_acc_last  = last;
    bus.i_acc_clear = clr;
    bus.i_in_vld    = 1'b1;
    step();
    bus.i_in_vld    = 1'b0;
    bus.i_acc_last  = 1'b0;
    bus.i_acc_clear = 1'b0;
  endtask

  initial begin
    bus.i_wdata      = '0;
    bus.i_mdata      = '0;
    bus.i_wdata_vld  = 1'b1;
    bus.i_mdata_vld  = 1'b1;
    bus.i_in_vld     = 1'b0;
    bus.i_mode       = 1'b0;
    bus.i_acc_last   = 1'b0;
    bus.i_acc_clear  = 1'b0;
    bus.i_result_rdy = 1'b0;
    step();
    step();
    i_rst = 1'b0;
    chk("rst_vld",    64'(bus.o_result_vld), 64'd0);
    chk("rst_result", 64'(bus.o_result), 64'd0);
    chk("rst_sat",    64'(bus.o_sat), 64'd0);
    chk("rst_busy",   64'(bus.o_busy), 64'd0);
    chk("rst_in_rdy", 64'(bus.o_in_rdy), 64'd1);

    // ADD 127+1 in every lane
    bus.i_result_rdy = 1'b1;
    beat(127, 1, 1'b0, 1'b0, 1'b0);
    chk("add_result", 64'(bus.o_result), rep(128));
    chk("add_vld",    64'(bus.o_result_vld), 64'd1);
    chk("add_sat",    64'(bus.o_sat), 64'd0);
    step();
    chk("add_vld_drop", 64'(bus.o_result_vld), 64'd0);

    // ADD with distinct lanes: 127+1, -128+-128, 5+-10, -1+0
    bus.i_wdata = {8'hFF, 8'h05, 8'h80, 8'h7F};
    bus.i_mdata = {8'h00, 8'hF6, 8'h80, 8'h01};
    bus.i_mode = 1'b0;
    bus.i_in_vld = 1'b1;
    step();
    bus.i_in_vld = 1'b0;
    chk("add_lanes", 64'(bus.o_result), 64'({12'hFFF, 12'hFFB, 12'hF00, 12'h080}));

    // Operand masking
    bus.i_mdata_vld = 1'b0;
    beat(-5, 100, 1'b0, 1'b0, 1'b0);
    chk("mask_b", 64'(bus.o_result), rep(-5));
    bus.i_mdata_vld = 1'b1;
    bus.i_wdata_vld = 1'b0;
    beat(-5, 100, 1'b0, 1'b0, 1'b0);
    chk("mask_a", 64'(bus.o_result), rep(100));
    bus.i_wdata_vld = 1'b1;
    step();

    // ACC group of three 100+100 beats
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    chk("acc_b1_vld",  64'(bus.o_result_vld), 64'd0);
    chk("acc_b1_busy", 64'(bus.o_busy), 64'd1);
    beat(100, 100, 1'b0, 1'b0, 1'b0);
    chk("acc_b2_vld",  64'(bus.o_result_vld), 64'd0);
    beat(100, 100, 1'b0, 1'b1, 1'b0);
    chk("acc_result", 64'(bus.o_result), rep(600));
    chk("acc_vld",    64'(bus.o_result_vld), 64'd1);
    chk("acc_sat",    64'(bus.o_sat), 64'd0);
    step();
    chk("acc_idle_busy", 64'(bus.o_busy), 64'd0);

    // Positive saturation: 11 x 254
    for (int k = 0; k < 11; k++) beat(127, 127, 1'b1, (k == 10), 1'b0);
    chk("satp_result", 64'(bus.o_result), rep(2047));
    chk("satp_sat",    64'(bus.o_sat), 64'hF);
    // Negative saturation: 9 x -256
    for (int k = 0; k < 9; k++) beat(-128, -128, 1'b1, (k == 8), 1'b0);
    chk("satn_result", 64'(bus.o_result), rep(-2048));
    chk("satn_sat",    64'(bus.o_sat), 64'hF);
    // Following group without overflow clears the sticky flags
    beat(1, 1, 1'b1, 1'b0, 1'b0);
    beat(1, 1, 1'b1, 1'b1, 1'b0);
    chk("sat_clr_result", 64'(bus.o_result), rep(4));
    chk("sat_clr_sat",    64'(bus.o_sat), 64'd0);
    step();

    // Backpressure: two ADD beats with downstream stalled
    bus.i_result_rdy = 1'b0;
    beat(10, 1, 1'b0, 1'b0, 1'b0);
    chk("bp_first",  64'(bus.o_result), rep(11));
    chk("bp_in_rdy", 64'(bus.o_in_rdy), 64'd0);
    set_ops(20, 2);
    bus.i_in_vld = 1'b1;
    step();
    chk("bp_hold_result", 64'(bus.o_result), rep(11));
    chk("bp_hold_vld",    64'(bus.o_result_vld), 64'd1);
    step();
    chk("bp_hold2_result", 64'(bus.o_result), rep(11));
    bus.i_result_rdy = 1'b1;
    #1;
    chk("bp_in_rdy_up", 64'(bus.o_in_rdy), 64'd1);
    step();
    bus.i_in_vld = 1'b0;
    chk("bp_second",     64'(bus.o_result), rep(22));
    chk("bp_second_vld", 64'(bus.o_result_vld), 64'd1);
    step();
    chk("bp_no_dup", 64'(bus.o_result_vld), 64'd0);

    // Reset mid-group, with a beat offered during reset
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b1;
    bus.i_in_vld = 1'b1;
    step();
    i_rst = 1'b0;
    bus.i_in_vld = 1'b0;
    chk("mrst_busy", 64'(bus.o_busy), 64'd0);
    chk("mrst_vld",  64'(bus.o_result_vld), 64'd0);
    beat(2, 3, 1'b1, 1'b1, 1'b0);
    chk("mrst_result", 64'(bus.o_result), rep(5));
    step();

    // Clear without a beat mid-group
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    bus.i_acc_clear = 1'b1;
    step();
    bus.i_acc_clear = 1'b0;
    chk("clr_busy", 64'(bus.o_busy), 64'd0);
    beat(2, 3, 1'b1, 1'b1, 1'b0);
    chk("clr_result", 64'(bus.o_result), rep(5));
    step();

    // Clear coincident with the closing beat starts a new group
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    beat(2, 3, 1'b1, 1'b1, 1'b1);
    chk("clrb_result", 64'(bus.o_result), rep(5));
    chk("clrb_vld",    64'(bus.o_result_vld), 64'd1);
    // Clear with an ADD-mode beat yields a single ADD result
    beat(100, 100, 1'b1, 1'b0, 1'b0);
    beat(7, -2, 1'b0, 1'b0, 1'b1);
    chk("clra_result", 64'(bus.o_result), rep(5));
    step();
    chk("clra_busy", 64'(bus.o_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pe_add_acc.md
PE_ADD_ACC -- requirements
Module: pe_add_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand width per lane.
REQ-002 SHALL have parameter DATA_COPIES, default 32, lane count.
REQ-003 SHALL have parameter ACC_WIDTH, default 16, signed result width per lane; legal only if ACC_WIDTH >= DATA_WIDTH+1.
REQ-004 SHALL have parameter SAT_EN, default 1; 1 = saturate, 0 = two's-complement wrap.
REQ-005 SHALL have one clock; reset is synchronous and active-high. Ports are i_clk (clock) and i_rst (reset).
REQ-006 i_clk  in  1  clock; all state on the rising edge.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_wdata  in  DATA_COPIES*DATA_WIDTH  signed operand A lanes, lane i at [DATA_WIDTH*i +: DATA_WIDTH].
REQ-009 i_wdata_vld  in  1  0 = operand A treated as zero in all lanes.
REQ-010 i_mdata  in  DATA_COPIES*DATA_WIDTH  signed operand B lanes.
REQ-011 i_mdata_vld  in  1  0 = operand B treated as zero in all lanes.
REQ-012 i_in_vld  in  1  input beat offered.
REQ-013 o_in_rdy  out  1  input beat can be accepted.
REQ-014 i_mode  in  1  0 = ADD (one result per beat), 1 = ACC (one result per group).
REQ-015 i_acc_last  in  1  accepted beat closes the ACC group.
REQ-016 i_acc_clear  in  1  discard any open ACC group.
REQ-017 o_result  out  DATA_COPIES*ACC_WIDTH  per-lane signed result.
REQ-018 o_result_vld  out  1  o_result valid.
REQ-019 i_result_rdy  in  1  downstream accepts o_result.
REQ-020 o_sat  out  DATA_COPIES  per-lane saturation flag, qualified by o_result_vld.
REQ-021 o_busy  out  1  group open or result pending.

Function
REQ-022 Beat accepted iff i_in_vld & o_in_rdy; output transfer iff o_result_vld & i_result_rdy.
REQ-023 o_in_rdy SHALL equal ~o_result_vld | i_result_rdy (combinational, no bubble at full throughput).
REQ-024 Per-lane sum SHALL be the masked A plus masked B, sign-extended to DATA_WIDTH+1 bits, exact.
REQ-025 FSM states IDLE (no group open) and ACC (group open); the result output register is separate from the FSM.
REQ-026 IDLE, accepted beat, i_mode=0: o_result lane = sum sign-extended to ACC_WIDTH; o_result_vld next cycle (latency 1); o_sat=0; stays IDLE.
REQ-027 IDLE, accepted beat, i_mode=1: acc = sum; if i_acc_last, emit acc next cycle and stay IDLE; else go to ACC.
REQ-028 ACC, accepted beat: acc = acc + sum; i_mode ignored (mode latched at group start); if i_acc_last, emit acc next cycle and go to IDLE.
REQ-029 Overflow of ACC_WIDTH with SAT_EN=1: clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1); per-lane sticky sat flag set for the group and reported on o_sat with the result. Sticky flags clear at group start.
REQ-030 With SAT_EN=0: wrap modulo 2^ACC_WIDTH; o_sat is constant 0.
REQ-031 i_acc_clear without an accepted beat: go to IDLE, drop acc and sticky flags; a pending o_result is unaffected.
REQ-032 i_acc_clear with an accepted beat: the beat starts a new group per REQ-026/027 (clear first, then beat).
REQ-033 o_result/o_sat SHALL hold stable while o_result_vld & ~i_result_rdy.
REQ-034 o_result_vld falls after transfer unless a new result loads in the same cycle.
REQ-035 o_busy = (state==ACC) | o_result_vld.

Reset
REQ-036 On i_rst: state IDLE; acc, sticky flags, o_result, o_sat = 0; o_result_vld = 0; o_busy = 0. o_in_rdy SHALL be 1 in the cycle after reset.
REQ-037 i_rst SHALL override every simultaneous beat, clear, or transfer; a reset mid-group discards the partial sum.

Verification (DATA_WIDTH=8, DATA_COPIES=4, ACC_WIDTH=12, SAT_EN=1)
REQ-038 ADD: lane0 A=127, B=1, both vld, i_result_rdy=1 -> next cycle lane0 = 0x080, o_result_vld=1 for one cycle, o_sat=0.
REQ-039 Mask: A=-5, B=100, i_mdata_vld=0 -> lane = 0xFFB (-5).
REQ-040 ACC: 3 beats of A=100, B=100, i_acc_last on beat 3 -> a single result of 600 (0x258) one cycle after beat 3; o_result_vld=0 after beats 1-2.
REQ-041 Saturation: 11 ACC beats of 127+127 -> 2047 (0x7FF) with o_sat lane=1. 9 beats of -128+-128 -> -2048 (0x800) with o_sat=1. A following group without overflow -> o_sat=0.
REQ-042 Backpressure: i_result_rdy=0, two ADD beats offered -> first accepted, o_in_rdy=0, o_result stable. Then i_result_rdy=1 -> both results delivered in order, no loss or duplication.
REQ-043 Reset/clear mid-group: accumulate 2 beats, then pulse i_rst (or i_acc_clear), then one beat of sum 5 with i_acc_last -> result 5.
